camera_capture_writer: RTL

- Write-side producer for the dual-clock framebuffer RAM.
- Runs in the CLOCK_24 domain and parses the camera's VSYNC/HREF/byte stream in YUV422 format (YUYV order).
- Extracts the luma (Y) bytes and drives them into the framebuffer write port: data byte, write enable, and linear write address.
- The VGA read side consumes the stored frame independently at CLOCK_25.

---
 rtl/camera_capture_writer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/camera_capture_writer.sv
// Camera YUV422 capture: extracts luma bytes from the VSYNC/HREF stream
// and writes them linearly into the framebuffer write port.
module camera_capture_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 20,
    parameter int Y_PHASE  = 0
) (
    input  logic              CLOCK_24,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic [7:0]        Y_in,
    output logic              en,
    output logic [ADDR_W-1:0] contador_C,
    output logic              frame_done,
    output logic              line_overrun,
    output logic              frame_short
);

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic Y_BIT = 1'(Y_PHASE);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t             state;
    logic               vs_r, vs_p, hr_r, hr_p;
    logic [7:0]         d_r;
    logic               phase;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  line_base;

    logic vs_fall, vs_rise, hr_rise, hr_fall;
    logic cur_ph, is_y, active_y, col_ok, row_ok, wr;
    logic [ROW_W-1:0] row_next;

    always_comb begin
        vs_fall  = vs_p & ~vs_r;
        vs_rise  = ~vs_p & vs_r;
        hr_rise  = ~hr_p & hr_r;
        hr_fall  = hr_p & ~hr_r;
        cur_ph   = hr_rise ? 1'b0 : phase;
        is_y     = hr_r && (cur_ph == Y_BIT);
        active_y = (state == ACTIVE) && is_y;
        col_ok   = col < COL_W'(H_ACTIVE);
        row_ok   = row < ROW_W'(V_ACTIVE);
        wr       = active_y && col_ok && row_ok;
        row_next = row;
        if (state == ACTIVE && hr_fall && row_ok)
            row_next = row + ROW_W'(1);
    end

    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            vs_r  <= 1'b0;
            vs_p  <= 1'b0;
            hr_r  <= 1'b0;
            hr_p  <= 1'b0;
            d_r   <= '0;
            phase <= 1'b0;
        end else begin
            vs_r  <= cam_vsync;
            vs_p  <= vs_r;
            hr_r  <= cam_href;
            hr_p  <= hr_r;
            d_r   <= cam_d;
            phase <= hr_r ? ~cur_ph : 1'b0;
        end
    end

    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            line_base    <= '0;
            Y_in         <= '0;
            en           <= 1'b0;
            contador_C   <= '0;
            frame_done   <= 1'b0;
            line_overrun <= 1'b0;
            frame_short  <= 1'b0;
        end else begin
            en         <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (capture_en)
                        state <= SYNC;
                end
                SYNC: begin
                    if (vs_fall) begin
                        state        <= ACTIVE;
                        col          <= '0;
                        row          <= '0;
                        line_base    <= '0;
                        contador_C   <= '0;
                        line_overrun <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (wr) begin
                        en         <= 1'b1;
                        Y_in       <= d_r;
                        contador_C <= line_base + ADDR_W'(col);
                        col        <= col + COL_W'(1);
                    end else if (active_y && row_ok) begin
                        line_overrun <= 1'b1;
                    end
                    // Line end is applied before a coincident frame end.
                    if (hr_fall) begin
                        col <= '0;
                        row <= row_next;
                        if (row_ok)
                            line_base <= line_base + ADDR_W'(H_ACTIVE);
                    end
                    if (vs_rise) begin
                        frame_done  <= 1'b1;
                        frame_short <= row_next < ROW_W'(V_ACTIVE);
                        state       <= capture_en ? SYNC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
